alarm_clock_core: RTL

Parametrised timekeeping and alarm engine for the Basys2 alarm-clock design; it is the successor to the fixed-function controller core. It keeps a 24-hour HH:MM:SS time, holds a programmable alarm, runs a ring/snooze state machine, and drives BCD digits to the display scanner. It has a fast-run mode for simulation and bench demos, and configurable clock rate, snooze length and ring timeout.

---
 rtl/al_pkg.sv | 27 ++
 rtl/al_tick_gen.sv | 54 +++++
 rtl/alarm_clock_core.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/al_pkg.sv
// Shared types and constants for the alarm-clock core: FSM states, BCD digit pair,
// time-field limits and the binary-to-BCD helper.
package al_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } al_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  function automatic bcd2_t to_bcd2(input logic [5:0] v);
    bcd2_t r;
    r.tens = 4'(v / 6'd10);
    r.ones = 4'(v % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/al_tick_gen.sv
// Seconds prescaler: one-cycle tick every TERM+1 cycles (slow or fast rate),
// cleared by time edits or any change of the fast input; also produces the colon blink.
module al_tick_gen
  import al_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int FAST_DIV = 256
) (
  input  logic MCLK,
  input  logic reset,
  input  logic fast,
  input  logic clr,
  output logic tick,
  output logic colon
);

  localparam int MAX_DIV = (CLK_HZ > FAST_DIV) ? CLK_HZ : FAST_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV);

  localparam logic [CNT_W-1:0] TERM_SLOW = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] TERM_FAST = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_SLOW = CNT_W'(CLK_HZ / 2);
  localparam logic [CNT_W-1:0] HALF_FAST = CNT_W'(FAST_DIV / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic [CNT_W-1:0] half;
  logic             fast_q;
  logic             fast_edge;
  logic             at_term;

  assign term      = fast ? TERM_FAST : TERM_SLOW;
  assign half      = fast ? HALF_FAST : HALF_SLOW;
  assign fast_edge = fast ^ fast_q;
  assign at_term   = (cnt == term);

  // A tick coinciding with a clear is dropped so the next second starts cleanly.
  assign tick  = at_term & ~clr & ~fast_edge;
  assign colon = (cnt < half);

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      fast_q <= 1'b0;
    end else begin
      fast_q <= fast;
      if (clr || fast_edge || at_term)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_clock_core.sv
// 24-hour timekeeping, programmable alarm and ring/snooze FSM with BCD digit output.
// Build option: define AL_SNOOZE_EN to include the SNOOZE state and its minute counter.
module alarm_clock_core
  import al_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FAST_DIV   = 256,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 1
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        fast,
  input  logic        set_alarm,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        alarm_en,
  input  logic        snooze,
  input  logic        stop,
  output logic [15:0] digits,
  output logic [5:0]  seconds,
  output logic        alarm_active,
  output logic        colon
);

  localparam logic [5:0] RING_LAST = 6'(RING_MIN - 1);

  logic [4:0] hour_r, hour_n, al_hour;
  logic [5:0] min_r, min_n, sec_r, sec_n, al_min;
  logic       tick, clr, min_tick, time_chg, alarm_hit;
  logic [5:0] ring_cnt;
  al_state_t  state;

  assign clr = ~set_alarm & (inc_min | inc_hour);

  al_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .FAST_DIV(FAST_DIV)
  ) u_tick (
    .MCLK (MCLK),
    .reset(reset),
    .fast (fast),
    .clr  (clr),
    .tick (tick),
    .colon(colon)
  );

  // Manual edits wrap each field on its own; only ticks carry upward.
  always_comb begin
    hour_n = hour_r;
    min_n  = min_r;
    sec_n  = sec_r;
    if (clr) begin
      sec_n = '0;
      if (inc_min)  min_n  = (min_r == MIN_MAX)   ? '0 : min_r + 6'd1;
      if (inc_hour) hour_n = (hour_r == HOUR_MAX) ? '0 : hour_r + 5'd1;
    end else if (tick) begin
      if (sec_r == SEC_MAX) begin
        sec_n = '0;
        if (min_r == MIN_MAX) begin
          min_n  = '0;
          hour_n = (hour_r == HOUR_MAX) ? '0 : hour_r + 5'd1;
        end else begin
          min_n = min_r + 6'd1;
        end
      end else begin
        sec_n = sec_r + 6'd1;
      end
    end
  end

  assign min_tick  = tick & (sec_r == SEC_MAX);
  assign alarm_hit = time_chg & (hour_r == al_hour) & (min_r == al_min) & (sec_r == 6'd0);

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      hour_r   <= '0;
      min_r    <= '0;
      sec_r    <= '0;
      al_hour  <= '0;
      al_min   <= '0;
      time_chg <= 1'b0;
    end else begin
      hour_r   <= hour_n;
      min_r    <= min_n;
      sec_r    <= sec_n;
      time_chg <= clr | tick;
      if (set_alarm && inc_min)  al_min  <= (al_min == MIN_MAX)   ? '0 : al_min + 6'd1;
      if (set_alarm && inc_hour) al_hour <= (al_hour == HOUR_MAX) ? '0 : al_hour + 5'd1;
    end
  end

`ifdef AL_SNOOZE_EN
  localparam logic [5:0] SNOOZE_LAST = 6'(SNOOZE_MIN - 1);
  logic [5:0] snz_cnt;
`else
  logic snooze_unused;
  assign snooze_unused = snooze;
`endif

  // Ring FSM; alarm_en low forces IDLE ahead of every other condition.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ring_cnt <= '0;
`ifdef AL_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else if (!alarm_en) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alarm_hit) begin
            state    <= ST_RINGING;
            ring_cnt <= '0;
          end
        end
        ST_RINGING: begin
          if (stop) begin
            state <= ST_IDLE;
`ifdef AL_SNOOZE_EN
          end else if (snooze) begin
            state   <= ST_SNOOZE;
            snz_cnt <= '0;
`endif
          end else if (min_tick) begin
            if (ring_cnt == RING_LAST) state <= ST_IDLE;
            else                       ring_cnt <= ring_cnt + 6'd1;
          end
        end
`ifdef AL_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (min_tick) begin
            if (snz_cnt == SNOOZE_LAST) begin
              state    <= ST_RINGING;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt + 6'd1;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign alarm_active = (state == ST_RINGING);
  assign seconds      = sec_r;
  assign digits       = set_alarm ? {to_bcd2({1'b0, al_hour}), to_bcd2(al_min)}
                                  : {to_bcd2({1'b0, hour_r}), to_bcd2(min_r)};

endmodule
